// File: rtl/cskip_adder_pipe_if.sv
// Streaming operand/result bundle for the pipelined carry-skip adder/subtractor.
// The master is the producer/consumer side; the slave is the adder.
interface cskip_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, sub, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, sub, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor: one BLOCK-bit skip block per register
// stage, so the carry resolves one block per clock behind a valid/ready handshake.
module cskip_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic               clk,
    input logic               rst_n,
    cskip_adder_pipe_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;

    logic             adv;
    logic             out_valid_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] sum_q;

    // Global stall: every stage, bubbles included, freezes when the result is blocked.
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Stage k sees the operand bits not yet consumed (REM wide) and the DONE
    // sum bits completed so far, including its own block.
    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int REM  = WIDTH - k * BLOCK;
        localparam int DONE = (k + 1) * BLOCK;

        logic [REM-1:0]   a_d;
        logic [REM-1:0]   b_d;
        logic             c_d;
        logic             v_d;
        logic [DONE-1:0]  sum_d;
        logic [BLOCK:0]   rc;
        logic [BLOCK-1:0] blk_x;
        logic [BLOCK-1:0] blk_s;
        logic             blk_p;
        logic             blk_c;

        if (k == 0) begin : g_in
            assign a_d   = bus.a;
            assign b_d   = bus.b ^ {WIDTH{bus.sub}};
            assign c_d   = bus.sub;
            assign v_d   = bus.in_valid;
            assign sum_d = blk_s;
        end else begin : g_reg
            logic [REM-1:0]       a_r;
            logic [REM-1:0]       b_r;
            logic [k*BLOCK-1:0]   s_r;
            logic                 c_r;
            logic                 v_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_r <= 1'b0;
                end else if (adv) begin
                    v_r <= g_stg[k-1].v_d;
                end
            end

            // NOTE: datapath flops carry no reset; only the valid bits decide
            // whether their contents mean anything, so a reset here buys nothing.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_r <= g_stg[k-1].a_d[REM+BLOCK-1:BLOCK];
                    b_r <= g_stg[k-1].b_d[REM+BLOCK-1:BLOCK];
                    s_r <= g_stg[k-1].sum_d;
                    c_r <= g_stg[k-1].blk_c;
                end
            end

            assign a_d   = a_r;
            assign b_d   = b_r;
            assign c_d   = c_r;
            assign v_d   = v_r;
            assign sum_d = {blk_s, s_r};
        end

        always_comb begin
            blk_x = a_d[BLOCK-1:0] ^ b_d[BLOCK-1:0];
            blk_s = '0;
            rc    = '0;
            rc[0] = c_d;
            for (int i = 0; i < BLOCK; i++) begin
                blk_s[i] = blk_x[i] ^ rc[i];
                rc[i+1]  = (a_d[i] & b_d[i]) | (blk_x[i] & rc[i]);
            end
        end

        // Skip mux: an all-propagate block passes its carry-in straight through.
        assign blk_p = &blk_x;
        assign blk_c = blk_p ? c_d : rc[BLOCK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= g_stg[NBLK-1].v_d;
            if (g_stg[NBLK-1].v_d) begin
                sum_q  <= g_stg[NBLK-1].sum_d;
                cout_q <= g_stg[NBLK-1].blk_c;
                ovf_q  <= g_stg[NBLK-1].blk_c ^ g_stg[NBLK-1].rc[BLOCK-1];
            end
        end
    end
endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Self-checking bench for cskip_adder_pipe (WIDTH=16, BLOCK=4, latency 4):
// directed vector table, handshake/bubble/reset sequences and a random stream.
module tb_cskip_adder_pipe;
    localparam int W   = 16;
    localparam int LAT = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    cskip_adder_pipe_if #(.WIDTH(W)) bus ();

    cskip_adder_pipe #(.WIDTH(W), .BLOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from the operand/result sign rule.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t         r;
        logic [W:0]   full;
        logic [W-1:0] be;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + (W+1)'(sub);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic randomize_inputs();
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.sub = 1'($urandom);
    endtask

    // Entered at posedge+1 with an empty pipeline.
    task automatic apply_one(input vec_t v, input string tag);
        int lat;
        bus.in_valid  = 1'b1;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.sub       = v.sub;
        bus.out_ready = 1'b1;
        #3;
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        randomize_inputs();
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'(LAT));
        check($sformatf("%s sum", tag), 32'(bus.sum), 32'(v.sum));
        check($sformatf("%s cout", tag), 32'(bus.cout), 32'(v.cout));
        check($sformatf("%s ovf", tag), 32'(bus.ovf), 32'(v.ovf));
        @(posedge clk); #1;
        check($sformatf("%s single", tag), 32'(bus.out_valid), 32'd0);
    endtask

    // Stream beats; rnd=0 gives back-to-back input with a 3-cycle output stall.
    task automatic run_stream(input int n_beats, input bit rnd, input string tag);
        res_t         q[$];
        res_t         e;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        logic         hold = 1'b0;
        logic [W+1:0] prev = '0;
        while ((sent < n_beats || q.size() > 0) && cyc < 5000) begin
            bus.in_valid  = (sent < n_beats) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            randomize_inputs();
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 5 && cyc < 8);
            #3;
            check($sformatf("%s in_ready c%0d", tag, cyc), 32'(bus.in_ready),
                  32'(!bus.out_valid || bus.out_ready));
            if (hold)
                check($sformatf("%s stable c%0d", tag, cyc),
                      32'({bus.out_valid, bus.sum, bus.cout, bus.ovf}), 32'({1'b1, prev}));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check($sformatf("%s spurious c%0d", tag, cyc), 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("%s result %0d", tag, got),
                          32'({bus.sum, bus.cout, bus.ovf}), 32'(e));
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.sub));
                sent++;
            end
            hold = bus.out_valid && !bus.out_ready;
            prev = {bus.sum, bus.cout, bus.ovf};
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("%s delivered", tag), 32'(got), 32'(n_beats));
        check($sformatf("%s leftover", tag), 32'(q.size()), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        res_t b_q[$];
        res_t e;
        int   waits;

        vecs[0] = '{a: 16'hA0A0, b: 16'hA0A0, sub: 1'b0, sum: 16'h4140, cout: 1'b1, ovf: 1'b1};
        vecs[1] = '{a: 16'h3D0F, b: 16'h0F0F, sub: 1'b0, sum: 16'h4C1E, cout: 1'b0, ovf: 1'b0};
        vecs[2] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 16'hFFFF, b: 16'hFFFF, sub: 1'b1, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 16'h0000, b: 16'h0000, sub: 1'b0, sum: 16'h0000, cout: 1'b0, ovf: 1'b0};

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        randomize_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) apply_one(vecs[i], $sformatf("vec%0d", i));

        run_stream(8, 1'b0, "stall");

        // Bubbles: 1/0 input pattern must reappear LAT cycles later.
        for (int t = 0; t < 14; t++) begin
            bus.in_valid = (t < 6) && (t % 2 == 0);
            randomize_inputs();
            bus.out_ready = 1'b1;
            #3;
            if (bus.in_valid && bus.in_ready) b_q.push_back(model(bus.a, bus.b, bus.sub));
            check($sformatf("bubble valid t%0d", t), 32'(bus.out_valid),
                  32'(t >= LAT && t < 6 + LAT && (t - LAT) % 2 == 0));
            if (bus.out_valid && b_q.size() > 0) begin
                e = b_q.pop_front();
                check($sformatf("bubble result t%0d", t),
                      32'({bus.sum, bus.cout, bus.ovf}), 32'(e));
            end
            @(posedge clk); #1;
        end

        // Reset mid-flight with a live result on the output.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'hA0A0;
            bus.b        = 16'hA0A0;
            bus.sub      = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        waits = 0;
        while (!bus.out_valid && waits < 10) begin
            @(posedge clk); #1;
            waits++;
        end
        check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset sum", 32'(bus.sum), 32'd0);
        check("midreset cout_ovf", 32'({bus.cout, bus.ovf}), 32'd0);
        check("midreset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset idle", 32'(bus.out_valid), 32'd0);
        apply_one('{a: 16'h1234, b: 16'h1111, sub: 1'b0, sum: 16'h2345, cout: 1'b0, ovf: 1'b0},
                  "after-reset");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("no stale %0d", i), 32'(bus.out_valid), 32'd0);
        end

        run_stream(150, 1'b1, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
